// File: rtl/axil_pkg.sv
// Shared definitions for the AXI4-Lite register slave: response codes, FSM
// state types and the byte-lane merge helper.
package axil_pkg;

   localparam logic [1:0] AXI_RESP_OKAY   = 2'd0;
   localparam logic [1:0] AXI_RESP_SLVERR = 2'd2;
   localparam logic [1:0] AXI_RESP_DECERR = 2'd3;

   // The merge helper works at a fixed maximum width; callers zero-extend and truncate.
   localparam int AXIL_MAX_DW = 256;
   localparam int AXIL_MAX_SW = AXIL_MAX_DW / 8;

   typedef enum logic {W_IDLE, W_RESP} axil_wr_state_t;
   typedef enum logic {R_IDLE, R_DATA} axil_rd_state_t;

   function automatic logic [AXIL_MAX_DW-1:0] apply_wstrb(
      input logic [AXIL_MAX_DW-1:0] old_v,
      input logic [AXIL_MAX_DW-1:0] data_v,
      input logic [AXIL_MAX_SW-1:0] strb_v
   );
      logic [AXIL_MAX_DW-1:0] res;
      res = old_v;
      for (int i = 0; i < AXIL_MAX_SW; i++) begin
         if (strb_v[i]) res[8*i +: 8] = data_v[8*i +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/axil_reg_slave.sv
// AXI4-Lite register slave: two RW control registers and two RO status registers
// in a 16-byte window at BASE_ADDR, with independent write and read FSMs.
module axil_reg_slave
   import axil_pkg::*;
#(
   parameter int                    DATA_WIDTH = 32,
   parameter int                    ADDR_WIDTH = 8,
   parameter int                    RESP_WIDTH = 2,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 8'h00
) (
   input  logic                    s_axi_aclk,
   input  logic                    s_axi_aresetn,
   input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
   input  logic                    s_axi_awvalid,
   output logic                    s_axi_awready,
   input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
   input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
   input  logic                    s_axi_wvalid,
   output logic                    s_axi_wready,
   output logic [RESP_WIDTH-1:0]   s_axi_bresp,
   output logic                    s_axi_bvalid,
   input  logic                    s_axi_bready,
   input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
   input  logic                    s_axi_arvalid,
   output logic                    s_axi_arready,
   output logic [DATA_WIDTH-1:0]   s_axi_rdata,
   output logic [RESP_WIDTH-1:0]   s_axi_rresp,
   output logic                    s_axi_rvalid,
   input  logic                    s_axi_rready,
   output logic [DATA_WIDTH-1:0]   ctrl0_o,
   output logic [DATA_WIDTH-1:0]   ctrl1_o,
   output logic [1:0]              ctrl_wr_o,
   input  logic [DATA_WIDTH-1:0]   status0_i,
   input  logic [DATA_WIDTH-1:0]   status1_i
);

   localparam int SW = DATA_WIDTH / 8;

   axil_wr_state_t          wr_state_q;
   axil_rd_state_t          rd_state_q;
   logic                    awready_q, wready_q, bvalid_q, arready_q, rvalid_q;
   logic [RESP_WIDTH-1:0]   bresp_q, rresp_q;
   logic [DATA_WIDTH-1:0]   rdata_q;
   logic                    aw_held_q, w_held_q;
   logic [ADDR_WIDTH-1:2]   awaddr_q;
   logic [DATA_WIDTH-1:0]   wdata_q;
   logic [SW-1:0]           wstrb_q;
   logic [DATA_WIDTH-1:0]   ctrl0_q, ctrl1_q, ctrl0_d, ctrl1_d;
   logic [1:0]              ctrl_wr_q, ctrl_wr_d;

   logic                    aw_take, w_take, wr_fire, wr_in, rd_in;
   logic [ADDR_WIDTH-1:2]   wr_addr;
   logic [DATA_WIDTH-1:0]   wr_data, wr_merge, rd_word;
   logic [SW-1:0]           wr_strb;
   logic [RESP_WIDTH-1:0]   wr_resp, rd_resp;

   // Byte offset bits take no part in decode.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0]};

   always_comb begin
      aw_take  = s_axi_awvalid & awready_q;
      w_take   = s_axi_wvalid & wready_q;
      wr_addr  = aw_held_q ? awaddr_q : s_axi_awaddr[ADDR_WIDTH-1:2];
      wr_data  = w_held_q ? wdata_q : s_axi_wdata;
      wr_strb  = w_held_q ? wstrb_q : s_axi_wstrb;
      wr_fire  = (wr_state_q == W_IDLE) & (aw_held_q | aw_take) & (w_held_q | w_take);
      wr_in    = (wr_addr[ADDR_WIDTH-1:4] == BASE_ADDR[ADDR_WIDTH-1:4]);
      wr_resp  = !wr_in     ? RESP_WIDTH'(AXI_RESP_DECERR) :
                 wr_addr[3] ? RESP_WIDTH'(AXI_RESP_SLVERR) : RESP_WIDTH'(AXI_RESP_OKAY);
      wr_merge = DATA_WIDTH'(apply_wstrb(AXIL_MAX_DW'(wr_addr[2] ? ctrl1_q : ctrl0_q),
                                         AXIL_MAX_DW'(wr_data), AXIL_MAX_SW'(wr_strb)));
      ctrl0_d   = ctrl0_q;
      ctrl1_d   = ctrl1_q;
      ctrl_wr_d = 2'b00;
      if (wr_fire && wr_in && !wr_addr[3]) begin
         if (wr_addr[2]) begin
            ctrl1_d      = wr_merge;
            ctrl_wr_d[1] = 1'b1;
         end else begin
            ctrl0_d      = wr_merge;
            ctrl_wr_d[0] = 1'b1;
         end
      end

      rd_in   = (s_axi_araddr[ADDR_WIDTH-1:4] == BASE_ADDR[ADDR_WIDTH-1:4]);
      rd_resp = rd_in ? RESP_WIDTH'(AXI_RESP_OKAY) : RESP_WIDTH'(AXI_RESP_DECERR);
      case (s_axi_araddr[3:2])
         2'd0:    rd_word = ctrl0_q;
         2'd1:    rd_word = ctrl1_q;
         2'd2:    rd_word = status0_i;
         default: rd_word = status1_i;
      endcase
      if (!rd_in) rd_word = '0;
   end

   // Write channel: collect AW and W in any order, then hold the B response.
   always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
      if (!s_axi_aresetn) begin
         wr_state_q <= W_IDLE;
         awready_q  <= 1'b0;
         wready_q   <= 1'b0;
         bvalid_q   <= 1'b0;
         bresp_q    <= '0;
         aw_held_q  <= 1'b0;
         w_held_q   <= 1'b0;
         awaddr_q   <= '0;
         wdata_q    <= '0;
         wstrb_q    <= '0;
         ctrl0_q    <= '0;
         ctrl1_q    <= '0;
         ctrl_wr_q  <= 2'b00;
      end else begin
         ctrl0_q   <= ctrl0_d;
         ctrl1_q   <= ctrl1_d;
         ctrl_wr_q <= ctrl_wr_d;
         case (wr_state_q)
            W_IDLE: begin
               if (aw_take) awaddr_q <= s_axi_awaddr[ADDR_WIDTH-1:2];
               if (w_take) begin
                  wdata_q <= s_axi_wdata;
                  wstrb_q <= s_axi_wstrb;
               end
               if (wr_fire) begin
                  wr_state_q <= W_RESP;
                  awready_q  <= 1'b0;
                  wready_q   <= 1'b0;
                  bvalid_q   <= 1'b1;
                  bresp_q    <= wr_resp;
                  aw_held_q  <= 1'b0;
                  w_held_q   <= 1'b0;
               end else begin
                  aw_held_q <= aw_held_q | aw_take;
                  w_held_q  <= w_held_q | w_take;
                  awready_q <= !(aw_held_q | aw_take);
                  wready_q  <= !(w_held_q | w_take);
               end
            end
            W_RESP: begin
               if (s_axi_bready) begin
                  wr_state_q <= W_IDLE;
                  bvalid_q   <= 1'b0;
                  awready_q  <= 1'b1;
                  wready_q   <= 1'b1;
               end
            end
            default: wr_state_q <= W_IDLE;
         endcase
      end
   end

   always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
      if (!s_axi_aresetn) begin
         rd_state_q <= R_IDLE;
         arready_q  <= 1'b0;
         rvalid_q   <= 1'b0;
         rdata_q    <= '0;
         rresp_q    <= '0;
      end else begin
         case (rd_state_q)
            R_IDLE: begin
               if (s_axi_arvalid && arready_q) begin
                  rd_state_q <= R_DATA;
                  arready_q  <= 1'b0;
                  rvalid_q   <= 1'b1;
                  rdata_q    <= rd_word;
                  rresp_q    <= rd_resp;
               end else begin
                  arready_q  <= 1'b1;
               end
            end
            R_DATA: begin
               if (s_axi_rready) begin
                  rd_state_q <= R_IDLE;
                  rvalid_q   <= 1'b0;
                  arready_q  <= 1'b1;
               end
            end
            default: rd_state_q <= R_IDLE;
         endcase
      end
   end

   assign s_axi_awready = awready_q;
   assign s_axi_wready  = wready_q;
   assign s_axi_bvalid  = bvalid_q;
   assign s_axi_bresp   = bresp_q;
   assign s_axi_arready = arready_q;
   assign s_axi_rvalid  = rvalid_q;
   assign s_axi_rdata   = rdata_q;
   assign s_axi_rresp   = rresp_q;
   assign ctrl0_o       = ctrl0_q;
   assign ctrl1_o       = ctrl1_q;
   assign ctrl_wr_o     = ctrl_wr_q;

endmodule
